// File: rtl/dir_access_arbiter_pkg.sv
// Shared encodings for the coherence-directory access arbiter: directory
// state codes, arbiter FSM state codes, the directory entry layout and a
// small requester-index helper.
package dir_access_arbiter_pkg;

  localparam int unsigned ADDR_W = 64;

  // Directory line states as stored in the single-ported directory.
  localparam logic [2:0] DIR_STATE_I = 3'b000;
  localparam logic [2:0] DIR_STATE_S = 3'b001;
  localparam logic [2:0] DIR_STATE_E = 3'b010;
  localparam logic [2:0] DIR_STATE_M = 3'b011;
  localparam logic [2:0] DIR_STATE_O = 3'b100;

  // Arbiter sequencer states; kept as plain constants so older blocks that
  // decode the state bus keep working.
  localparam logic [2:0] ARB_IDLE     = 3'd0;
  localparam logic [2:0] ARB_LOOKUP   = 3'd1;
  localparam logic [2:0] ARB_RESP     = 3'd2;
  localparam logic [2:0] ARB_WAIT_UPD = 3'd3;
  localparam logic [2:0] ARB_UPDATE   = 3'd4;

  // One directory entry as seen on the lookup and update ports.
  typedef struct packed {
    logic [2:0] state;
    logic [1:0] presence;
    logic [1:0] tip;
  } dir_entry_t;

  // Requester index to one-hot requester vector.
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dir_access_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-input round-robin picker. Purely combinational; the
// pointer names the requester that wins when both are asking.
module dir_access_arbiter_rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Single requester always wins; a tie goes to the pointed-at requester.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dir_access_arbiter.sv
// dir_access_arbiter: serialises atomic lookup/update transactions from two
// L1 channel handlers onto the single-ported coherence directory. Only one
// transaction is open at a time, so an entry cannot change between a
// requester's lookup and its update.
//
// Optional feature: define DIR_ARB_TIMEOUT_EN to enable the WAIT_UPD
// watchdog (TIMEOUT_CYCLES is used only in that build). Without it the
// arbiter waits for the owner's update indefinitely and
// timeout_err/timeout_owner are tied low.
module dir_access_arbiter
  import dir_access_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
)
(
  input  logic         clk,
  input  logic         rst_n,
  // Requester address handshake
  input  logic [1:0]   req_valid,
  input  logic [127:0] req_addr,
  output logic [1:0]   req_ready,
  // Lookup result back to the owner
  output logic [1:0]   rsp_valid,
  output logic [2:0]   rsp_state,
  output logic [1:0]   rsp_presence,
  output logic [1:0]   rsp_tip,
  // Update / close from the owner
  input  logic [1:0]   upd_valid,
  input  logic [1:0]   upd_write,
  input  logic [5:0]   upd_state,
  input  logic [3:0]   upd_presence,
  input  logic [3:0]   upd_tip,
  output logic [1:0]   upd_ready,
  // Directory lookup port
  output logic         dir_lookup_req,
  output logic [63:0]  dir_lookup_addr,
  input  logic [2:0]   dir_lookup_state,
  input  logic [1:0]   dir_lookup_presence,
  input  logic [1:0]   dir_lookup_tip,
  // Directory update port
  output logic         dir_update_req,
  output logic [63:0]  dir_update_addr,
  output logic [2:0]   dir_update_state,
  output logic [1:0]   dir_update_presence,
  output logic [1:0]   dir_update_tip,
  input  logic         dir_update_done,
  // Watchdog
  output logic         timeout_err,
  output logic         timeout_owner
);

  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  dir_entry_t        rsp_q, rsp_d;
  dir_entry_t        upd_q, upd_d;
  logic [1:0]        grant;
  logic              wd_expire;

  dir_access_arbiter_rr_arbiter_2 u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Transaction sequencer: next state, latches and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    rsp_d    = rsp_q;
    upd_d    = upd_q;
    case (state_q)
      ARB_IDLE: begin
        // grant is non-zero exactly when some req_valid bit is set, and the
        // granted bit is driven on req_ready, so this is the handshake.
        if (grant != 2'b00) begin
          owner_d = grant[1];
          addr_d  = req_addr[{grant[1], 6'd0} +: ADDR_W];
          state_d = ARB_LOOKUP;
        end
      end
      ARB_LOOKUP: begin
        rsp_d.state    = dir_lookup_state;
        rsp_d.presence = dir_lookup_presence;
        rsp_d.tip      = dir_lookup_tip;
        state_d        = ARB_RESP;
      end
      ARB_RESP: begin
        state_d = ARB_WAIT_UPD;
      end
      ARB_WAIT_UPD: begin
        if (upd_valid[owner_q]) begin
          if (upd_write[owner_q]) begin
            upd_d.state    = owner_q ? upd_state[5:3]    : upd_state[2:0];
            upd_d.presence = owner_q ? upd_presence[3:2] : upd_presence[1:0];
            upd_d.tip      = owner_q ? upd_tip[3:2]      : upd_tip[1:0];
            state_d        = ARB_UPDATE;
          end else begin
            state_d  = ARB_IDLE;
            rr_ptr_d = ~owner_q;
          end
        end else if (wd_expire) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = ~owner_q;
        end
      end
      ARB_UPDATE: begin
        if (dir_update_done) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = ~owner_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Sequencer state; reset drops any open transaction without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      addr_q   <= '0;
      rsp_q    <= '0;
      upd_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      rsp_q    <= rsp_d;
      upd_q    <= upd_d;
    end
  end

`ifdef DIR_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_err_q;
  logic       timeout_owner_q, timeout_owner_d;

  // Watchdog: counter holds the number of completed WAIT_UPD cycles; the
  // wait expires when the TIMEOUT_CYCLES-th cycle ends with no update.
  always_comb begin
    wd_cnt_d        = wd_cnt_q;
    timeout_owner_d = timeout_owner_q;
    wd_expire       = (state_q == ARB_WAIT_UPD) && !upd_valid[owner_q] &&
                      (wd_cnt_q == TIMEOUT_CYCLES - 8'd1);
    if (state_q == ARB_RESP) begin
      wd_cnt_d = 8'd0;
    end else if (state_q == ARB_WAIT_UPD) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
    if (wd_expire) begin
      timeout_owner_d = owner_q;
    end
  end

  // Watchdog registers; timeout_err is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q        <= 8'd0;
      timeout_err_q   <= 1'b0;
      timeout_owner_q <= 1'b0;
    end else begin
      wd_cnt_q        <= wd_cnt_d;
      timeout_err_q   <= wd_expire;
      timeout_owner_q <= timeout_owner_d;
    end
  end

  assign timeout_err   = timeout_err_q;
  assign timeout_owner = timeout_owner_q;
`else
  assign wd_expire     = 1'b0;
  assign timeout_err   = 1'b0;
  assign timeout_owner = 1'b0;
`endif

  // Outputs decoded from registered state; req_ready is the only
  // combinational path and is gated by reset so it reads 0 while held.
  always_comb begin
    req_ready = ((state_q == ARB_IDLE) && rst_n) ? grant : 2'b00;
    rsp_valid = (state_q == ARB_RESP) ? req_onehot(owner_q) : 2'b00;
    upd_ready = (state_q == ARB_WAIT_UPD) ? req_onehot(owner_q) : 2'b00;
  end

  assign rsp_state           = rsp_q.state;
  assign rsp_presence        = rsp_q.presence;
  assign rsp_tip             = rsp_q.tip;
  assign dir_lookup_req      = (state_q == ARB_LOOKUP);
  assign dir_lookup_addr     = addr_q;
  assign dir_update_req      = (state_q == ARB_UPDATE);
  assign dir_update_addr     = addr_q;
  assign dir_update_state    = upd_q.state;
  assign dir_update_presence = upd_q.presence;
  assign dir_update_tip      = upd_q.tip;

endmodule
